// File: rtl/dest_fifo_reader_if.sv
// FIFO-side and receive-side signal bundle for the destination FIFO reader.
// master = reader (drives pops and the received word), slave = FIFOs/sink side.
interface dest_fifo_reader_if #(
  parameter int DATA_W = 6
);
  logic              empty_d0;
  logic              empty_d1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              pop_d0;
  logic              pop_d1;
  logic [DATA_W-1:0] data_rx;
  logic              valid_rx;
  logic              src_rx;

  modport master (
    input  empty_d0, empty_d1, data_out0, data_out1,
    output pop_d0, pop_d1, data_rx, valid_rx, src_rx
  );

  modport slave (
    output empty_d0, empty_d1, data_out0, data_out1,
    input  pop_d0, pop_d1, data_rx, valid_rx, src_rx
  );
endinterface

// File: rtl/dest_fifo_reader.sv
// Drains destination FIFOs D0/D1 with burst-limited round-robin and re-registers each word with its source tag.
// Optional DEST_CHECK_EN: sticky err_dest when a word's destination bit disagrees with the FIFO it came from.
module dest_fifo_reader #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8,
  parameter int BURST  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  dest_fifo_reader_if.master   bus,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic                 busy,
  output logic                 err_dest
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [BW-1:0]     burst_r;
  logic [BW-1:0]     burst_s;
  logic              pop0_s;
  logic              pop1_s;
  logic              inflight0_r;
  logic              inflight1_r;
  logic [DATA_W-1:0] data_rx_r;
  logic              valid_rx_r;
  logic              src_rx_r;
  logic [CNT_W-1:0]  cnt0_r;
  logic [CNT_W-1:0]  cnt1_r;

  // Pop requests: only from the FIFO owned by the current state, never while empty or in reset
  always_comb begin
    pop0_s = 1'b0;
    pop1_s = 1'b0;
    if (!reset) begin
      pop0_s = (state_r == RD0) && enable && !bus.empty_d0;
      pop1_s = (state_r == RD1) && enable && !bus.empty_d1;
    end else begin
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end
  end

  // Next-state and burst counter; a finished burst hands over only if the other FIFO has data
  always_comb begin
    state_s = state_r;
    burst_s = burst_r;
    case (state_r)
      IDLE: begin
        burst_s = {BW{1'b0}};
        if (enable && !bus.empty_d0) begin
          state_s = RD0;
        end else if (enable && !bus.empty_d1) begin
          state_s = RD1;
        end else begin
          state_s = IDLE;
        end
      end
      RD0: begin
        if (!enable) begin
          state_s = IDLE;
          burst_s = {BW{1'b0}};
        end else if ((pop0_s && (burst_r == BURST_LAST)) || bus.empty_d0) begin
          burst_s = {BW{1'b0}};
          if (!bus.empty_d1) begin
            state_s = RD1;
          end else if (!bus.empty_d0) begin
            state_s = RD0;
          end else begin
            state_s = IDLE;
          end
        end else if (pop0_s) begin
          burst_s = burst_r + BW'(1);
        end else begin
          burst_s = burst_r;
        end
      end
      RD1: begin
        if (!enable) begin
          state_s = IDLE;
          burst_s = {BW{1'b0}};
        end else if ((pop1_s && (burst_r == BURST_LAST)) || bus.empty_d1) begin
          burst_s = {BW{1'b0}};
          if (!bus.empty_d0) begin
            state_s = RD0;
          end else if (!bus.empty_d1) begin
            state_s = RD1;
          end else begin
            state_s = IDLE;
          end
        end else if (pop1_s) begin
          burst_s = burst_r + BW'(1);
        end else begin
          burst_s = burst_r;
        end
      end
      default: begin
        state_s = IDLE;
        burst_s = {BW{1'b0}};
      end
    endcase
  end

  // FSM state and burst registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      burst_r <= {BW{1'b0}};
    end else begin
      state_r <= state_s;
      burst_r <= burst_s;
    end
  end

  // In-flight flags: a popped word is delivered even if enable drops afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight0_r <= 1'b0;
      inflight1_r <= 1'b0;
    end else begin
      inflight0_r <= pop0_s;
      inflight1_r <= pop1_s;
    end
  end

  // Receive register: capture FIFO read data the cycle after the pop, tagged with its source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_rx_r  <= {DATA_W{1'b0}};
      valid_rx_r <= 1'b0;
      src_rx_r   <= 1'b0;
    end else begin
      valid_rx_r <= inflight0_r | inflight1_r;
      if (inflight0_r) begin
        data_rx_r <= bus.data_out0;
        src_rx_r  <= 1'b0;
      end else if (inflight1_r) begin
        data_rx_r <= bus.data_out1;
        src_rx_r  <= 1'b1;
      end else begin
        data_rx_r <= data_rx_r;
        src_rx_r  <= src_rx_r;
      end
    end
  end

  // Per-destination word counters, wrapping silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (valid_rx_r) begin
      if (src_rx_r) begin
        cnt1_r <= cnt1_r + CNT_W'(1);
      end else begin
        cnt0_r <= cnt0_r + CNT_W'(1);
      end
    end else begin
      cnt0_r <= cnt0_r;
      cnt1_r <= cnt1_r;
    end
  end

`ifdef DEST_CHECK_EN
  logic err_r;

  function automatic logic dest_mismatch(input logic [DATA_W-1:0] word, input logic src);
    dest_mismatch = (word[DATA_W-2] != src);
  endfunction

  // Sticky routing error: the word's destination bit must name the FIFO it arrived through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (valid_rx_r && dest_mismatch(data_rx_r, src_rx_r)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_dest = err_r;
`else
  assign err_dest = 1'b0;
`endif

  assign bus.pop_d0   = pop0_s;
  assign bus.pop_d1   = pop1_s;
  assign bus.data_rx  = data_rx_r;
  assign bus.valid_rx = valid_rx_r;
  assign bus.src_rx   = src_rx_r;
  assign cnt_d0       = cnt0_r;
  assign cnt_d1       = cnt1_r;
  assign busy         = (state_r != IDLE) | inflight0_r | inflight1_r;

endmodule

// File: tb/tb_dest_fifo_reader.sv
// Directed bench for dest_fifo_reader with behavioural D0/D1 FIFO models.
module tb_dest_fifo_reader;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;
  localparam int BURST  = 4;
`ifdef DEST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic fifo_clr = 1'b0;
  logic [CNT_W-1:0] cnt_d0;
  logic [CNT_W-1:0] cnt_d1;
  logic busy;
  logic err_dest;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] mem0 [0:1023];
  logic [DATA_W-1:0] mem1 [0:1023];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  int underflow = 0;
  int both_pop = 0;

  dest_fifo_reader_if #(.DATA_W(DATA_W)) bus();

  dest_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .busy(busy), .err_dest(err_dest)
  );

  always #5 clk = ~clk;

  assign bus.empty_d0 = (rd0 == wr0);
  assign bus.empty_d1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (bus.pop_d0) begin
        if (rd0 == wr0) underflow <= underflow + 1;
        else begin
          bus.data_out0 <= mem0[rd0 % 1024];
          rd0 <= rd0 + 1;
        end
      end
      if (bus.pop_d1) begin
        if (rd1 == wr1) underflow <= underflow + 1;
        else begin
          bus.data_out1 <= mem1[rd1 % 1024];
          rd1 <= rd1 + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.pop_d0 && bus.pop_d1) both_pop <= both_pop + 1;
  end

  task automatic push0(input logic [DATA_W-1:0] d);
    mem0[wr0 % 1024] = d;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [DATA_W-1:0] d);
    mem1[wr1 % 1024] = d;
    wr1 = wr1 + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    fifo_clr = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    push0(6'h05);
    push1(6'h16);
    @(negedge clk);
    tests++;
    if ({bus.pop_d0, bus.pop_d1} !== 2'b00) begin
      fails++; $display("FAIL reset_pops: got %b expected 00", {bus.pop_d0, bus.pop_d1});
    end
    tests++;
    if ({bus.data_rx, bus.valid_rx, bus.src_rx, busy, err_dest} !== 10'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {bus.data_rx, bus.valid_rx, bus.src_rx, busy, err_dest});
    end
    tests++;
    if ({cnt_d0, cnt_d1} !== 16'd0) begin
      fails++; $display("FAIL reset_counters: got %h expected 0", {cnt_d0, cnt_d1});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.pop_d0, bus.pop_d1} !== 2'b10) begin
      fails++; $display("FAIL reset_release_pop: got %b expected 10", {bus.pop_d0, bus.pop_d1});
    end
    repeat (10) @(negedge clk);
    tests++;
    if ({cnt_d0, cnt_d1} !== {8'd1, 8'd1}) begin
      fails++; $display("FAIL reset_drain_counts: got %h expected 0101", {cnt_d0, cnt_d1});
    end
  endtask

  task automatic test_d0_only();
    int np = 0, nv = 0, first = -1, last = -1, bad1 = 0;
    logic [DATA_W-1:0] expd = 6'h01;
    do_reset();
    for (int i = 1; i <= 10; i++) push0(DATA_W'(i));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.pop_d1) bad1++;
      if (bus.pop_d0) begin
        if (first < 0) first = c;
        last = c;
        np++;
      end
      if (bus.valid_rx) begin
        tests++;
        if ({bus.data_rx, bus.src_rx} !== {expd, 1'b0}) begin
          fails++; $display("FAIL d0_word: got %h/%b expected %h/0", bus.data_rx, bus.src_rx, expd);
        end
        expd = expd + 6'h01;
        nv++;
      end
    end
    tests++;
    if (np !== 10 || (last - first) !== 9 || bad1 !== 0) begin
      fails++; $display("FAIL d0_pops: got %0d pops over %0d cycles (d1 %0d) expected 10 over 10", np, last - first + 1, bad1);
    end
    tests++;
    if (nv !== 10) begin
      fails++; $display("FAIL d0_valid_count: got %0d expected 10", nv);
    end
    tests++;
    if ({cnt_d0, cnt_d1, busy} !== {8'd10, 8'd0, 1'b0}) begin
      fails++; $display("FAIL d0_counts: got %0d/%0d busy %b expected 10/0 busy 0", cnt_d0, cnt_d1, busy);
    end
  endtask

  task automatic test_fairness();
    logic [15:0] seq = 16'h0000;
    logic [DATA_W-1:0] expw [16] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h11, 6'h12, 6'h13, 6'h14,
                                     6'h05, 6'h06, 6'h07, 6'h08, 6'h15, 6'h16, 6'h17, 6'h18};
    int np = 0, nv = 0, first = -1, last = -1;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      push0(DATA_W'(i));
      push1(DATA_W'(16 + i));
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.pop_d0 || bus.pop_d1) begin
        if (first < 0) first = c;
        last = c;
        if (np < 16) seq[np] = bus.pop_d1;
        np++;
      end
      if (bus.valid_rx) begin
        if (nv < 16) begin
          tests++;
          if ({bus.data_rx, bus.src_rx} !== {expw[nv], expw[nv][4]}) begin
            fails++; $display("FAIL rr_word%0d: got %h/%b expected %h/%b", nv, bus.data_rx, bus.src_rx, expw[nv], expw[nv][4]);
          end
        end
        nv++;
      end
    end
    tests++;
    if (seq !== 16'hF0F0 || np !== 16) begin
      fails++; $display("FAIL rr_order: got %h (%0d pops) expected f0f0 (16 pops)", seq, np);
    end
    tests++;
    if ((last - first) !== 15) begin
      fails++; $display("FAIL rr_no_gap: got span %0d expected 16", last - first + 1);
    end
    tests++;
    if ({cnt_d0, cnt_d1} !== {8'd8, 8'd8}) begin
      fails++; $display("FAIL rr_counts: got %0d/%0d expected 8/8", cnt_d0, cnt_d1);
    end
  endtask

  task automatic test_enable_drop();
    logic [DATA_W-1:0] expw [8] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h11, 6'h12};
    int np = 0, nv = 0, late = 0, first_pop = 0;
    do_reset();
    for (int i = 1; i <= 6; i++) push0(DATA_W'(i));
    push1(6'h11);
    push1(6'h12);
    for (int c = 0; c < 20 && np < 2; c++) begin
      @(negedge clk);
      if (bus.pop_d0 || bus.pop_d1) np++;
      if (bus.valid_rx) nv++;
    end
    @(posedge clk);
    #1 enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.pop_d0 || bus.pop_d1) late++;
      if (bus.valid_rx) begin
        if (nv < 8) begin
          tests++;
          if (bus.data_rx !== expw[nv]) begin
            fails++; $display("FAIL drop_word%0d: got %h expected %h", nv, bus.data_rx, expw[nv]);
          end
        end
        nv++;
      end
    end
    tests++;
    if (np !== 2 || late !== 0 || nv !== 2) begin
      fails++; $display("FAIL drop_stop: got pops %0d+%0d valids %0d expected 2+0 valids 2", np, late, nv);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL drop_busy: got %b expected 0", busy);
    end
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (first_pop == 0 && (bus.pop_d0 || bus.pop_d1)) first_pop = bus.pop_d1 ? 2 : 1;
      if (bus.valid_rx) begin
        if (nv < 8) begin
          tests++;
          if (bus.data_rx !== expw[nv]) begin
            fails++; $display("FAIL resume_word%0d: got %h expected %h", nv, bus.data_rx, expw[nv]);
          end
        end
        nv++;
      end
    end
    tests++;
    if (first_pop !== 1) begin
      fails++; $display("FAIL resume_first_d0: got %0d expected 1", first_pop);
    end
    tests++;
    if ({cnt_d0, cnt_d1} !== {8'd6, 8'd2}) begin
      fails++; $display("FAIL resume_counts: got %0d/%0d expected 6/2", cnt_d0, cnt_d1);
    end
  endtask

  task automatic test_wrap();
    int nv = 0, bad0 = 0, u0;
    logic saw255 = 1'b0;
    u0 = underflow;
    do_reset();
    for (int i = 0; i < 257; i++) push1(6'h10 | DATA_W'(i[3:0]));
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.pop_d0) bad0++;
      if (bus.valid_rx) nv++;
      if (cnt_d1 == 8'd255) saw255 = 1'b1;
    end
    tests++;
    if (nv !== 257 || bad0 !== 0) begin
      fails++; $display("FAIL wrap_words: got %0d (d0 pops %0d) expected 257 (0)", nv, bad0);
    end
    tests++;
    if ({cnt_d0, cnt_d1, saw255} !== {8'd0, 8'd1, 1'b1}) begin
      fails++; $display("FAIL wrap_count: got %0d/%0d seen255 %b expected 0/1 seen255 1", cnt_d0, cnt_d1, saw255);
    end
    tests++;
    if (underflow !== u0) begin
      fails++; $display("FAIL wrap_underflow: got %0d expected %0d", underflow, u0);
    end
  endtask

  task automatic test_dest_check();
    do_reset();
    push0(6'h10);
    repeat (6) @(negedge clk);
    tests++;
    if (err_dest !== EXP_ERR) begin
      fails++; $display("FAIL dest_err_set: got %b expected %b", err_dest, EXP_ERR);
    end
    push0(6'h01);
    repeat (6) @(negedge clk);
    tests++;
    if ({err_dest, cnt_d0} !== {EXP_ERR, 8'd2}) begin
      fails++; $display("FAIL dest_err_sticky: got %b/%0d expected %b/2", err_dest, cnt_d0, EXP_ERR);
    end
    do_reset();
    tests++;
    if (err_dest !== 1'b0) begin
      fails++; $display("FAIL dest_err_reset: got %b expected 0", err_dest);
    end
  endtask

  initial begin
    test_reset();
    test_d0_only();
    test_fairness();
    test_enable_drop();
    test_wrap();
    test_dest_check();
    tests++;
    if (underflow !== 0 || both_pop !== 0) begin
      fails++; $display("FAIL pop_safety: got underflow %0d dual %0d expected 0/0", underflow, both_pop);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
